// File: rtl/chip_to_symbol_despreader.sv
// ---------------------------------------------------------------------------
// chip_to_symbol_despreader
//
// Purpose: slides a 32-chip window over a hard-decision chip stream, finds
// symbol alignment by matching the symbol-0 preamble, then decodes each
// aligned 32-chip window to the nearest of 16 fixed chip sequences
// (minimum Hamming distance).
//
// Ports:
//   i_clk           - clock, all state updates on its rising edge
//   i_rst_n         - asynchronous active-low reset
//   i_chip          - hard-decision chip
//   i_chip_valid    - qualifies i_chip; everything holds while low
//   o_symbol        - decoded symbol, held between strobes
//   o_symbol_valid  - one-cycle strobe qualifying o_symbol / o_distance
//   o_distance      - Hamming distance of the emitted symbol (0..32)
//   o_locked        - high while symbol alignment is held
//
// State  | meaning
// -------+--------------------------------------------------------------
// SEARCH | filling window, comparing every chip against symbol 0
// LOCKED | aligned; decode every 32nd valid chip, count missed windows
// ---------------------------------------------------------------------------
module chip_to_symbol_despreader #(
    parameter int CHIP_WIDTH   = 32,
    parameter int SYMBOL_WIDTH = 4,
    parameter int NUM_OF_CHIPS = 16,
    parameter int MAX_ERR      = 6,
    parameter int LOSS_COUNT   = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_chip,
    input  logic                    i_chip_valid,
    output logic [SYMBOL_WIDTH-1:0] o_symbol,
    output logic                    o_symbol_valid,
    output logic [5:0]              o_distance,
    output logic                    o_locked
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Symbol 0 written in air order: leftmost character is c0, so c_i sits
    // at bit (31 - i) of this literal.
    localparam logic [31:0] SEQ0_AIR   = 32'b11011001110000110101001000101110;
    localparam logic [5:0]  MAX_ERR_D  = 6'(MAX_ERR);
    localparam logic [5:0]  FULL_FILL  = 6'(CHIP_WIDTH);
    localparam logic [5:0]  LAST_FILL  = 6'(CHIP_WIDTH - 1);
    localparam logic [3:0]  LOSS_LIMIT = 4'(LOSS_COUNT);

    // Candidate k as a window-ordered vector (bit i = chip c_i(k)).
    // 1..7 are rotations of symbol 0 by 4k chips; 8..15 additionally invert
    // the odd-indexed chips of k-8.
    function automatic logic [CHIP_WIDTH-1:0] chip_seq(input int k);
        logic [CHIP_WIDTH-1:0] s;
        int base;
        int src;
        base = k % 8;
        s    = '0;
        for (int i = 0; i < CHIP_WIDTH; i++) begin
            src  = (i - 4 * base + CHIP_WIDTH) % CHIP_WIDTH;
            s[i] = SEQ0_AIR[31 - src];
            if (k >= 8 && (i % 2) == 1) begin
                s[i] = ~s[i];
            end
        end
        return s;
    endfunction

    // Result is at most 32, so 6 bits never overflow.
    function automatic logic [5:0] popcount(input logic [CHIP_WIDTH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < CHIP_WIDTH; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    logic [0:0]              r_state;
    logic [CHIP_WIDTH-1:0]   r_window;
    logic [5:0]              r_fill;
    logic [4:0]              r_chip_cnt;
    logic [3:0]              r_miss;
    logic [SYMBOL_WIDTH-1:0] r_symbol;
    logic [5:0]              r_distance;
    logic                    r_symbol_valid;

    logic [CHIP_WIDTH-1:0]   w_table [NUM_OF_CHIPS];
    logic [CHIP_WIDTH-1:0]   w_window_next;
    logic [5:0]              w_dist [NUM_OF_CHIPS];
    logic [5:0]              w_best_dist;
    logic [SYMBOL_WIDTH-1:0] w_best_sym;
    logic                    w_unused_oldest;

    for (genvar k = 0; k < NUM_OF_CHIPS; k++) begin : g_table
        assign w_table[k] = chip_seq(k);
    end

    // Newest chip enters at the top; the oldest chip drops out of bit 0
    // and has no other reader.
    assign w_window_next   = {i_chip, r_window[CHIP_WIDTH-1:1]};
    assign w_unused_oldest = r_window[0];

    // All decisions are taken on the window that includes the chip being
    // sampled on this edge, so results appear the cycle after that chip.
    always_comb begin
        for (int k = 0; k < NUM_OF_CHIPS; k++) begin
            w_dist[k] = popcount(w_window_next ^ w_table[k]);
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best_dist = w_dist[0];
        w_best_sym  = '0;
        for (int k = 1; k < NUM_OF_CHIPS; k++) begin
            if (w_dist[k] < w_best_dist) begin
                w_best_dist = w_dist[k];
                w_best_sym  = SYMBOL_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_SEARCH;
            r_window       <= '0;
            r_fill         <= '0;
            r_chip_cnt     <= '0;
            r_miss         <= '0;
            r_symbol       <= '0;
            r_distance     <= '0;
            r_symbol_valid <= 1'b0;
        end else begin
            r_symbol_valid <= 1'b0;
            if (i_chip_valid) begin
                r_window <= w_window_next;
                case (r_state)
                    ST_SEARCH: begin
                        if (r_fill != FULL_FILL) begin
                            r_fill <= r_fill + 6'd1;
                        end
                        // r_fill >= 31 means this chip brings the fill to 32.
                        if (r_fill >= LAST_FILL && w_dist[0] <= MAX_ERR_D) begin
                            r_state        <= ST_LOCKED;
                            r_chip_cnt     <= '0;
                            r_miss         <= '0;
                            r_symbol       <= '0;
                            r_distance     <= w_dist[0];
                            r_symbol_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_chip_cnt <= r_chip_cnt + 5'd1;
                        if (r_chip_cnt == 5'd31) begin
                            if (w_best_dist <= MAX_ERR_D) begin
                                r_symbol       <= w_best_sym;
                                r_distance     <= w_best_dist;
                                r_symbol_valid <= 1'b1;
                                r_miss         <= '0;
                            end else if (r_miss + 4'd1 >= LOSS_LIMIT) begin
                                // Dropping lock: the next 32 valid chips must
                                // refill the window before any compare.
                                r_state <= ST_SEARCH;
                                r_fill  <= '0;
                                r_miss  <= '0;
                            end else begin
                                r_miss <= r_miss + 4'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_symbol       = r_symbol;
    assign o_distance     = r_distance;
    assign o_symbol_valid = r_symbol_valid;
    assign o_locked       = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_chip_to_symbol_despreader.sv
module tb_chip_to_symbol_despreader;

    localparam int LOSS = 2;
    localparam int MAXE = 6;

    logic       i_clk        = 1'b0;
    logic       i_rst_n      = 1'b1;
    logic       i_chip       = 1'b0;
    logic       i_chip_valid = 1'b0;
    logic [3:0] o_symbol;
    logic       o_symbol_valid;
    logic [5:0] o_distance;
    logic       o_locked;

    chip_to_symbol_despreader dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_chip         (i_chip),
        .i_chip_valid   (i_chip_valid),
        .o_symbol       (o_symbol),
        .o_symbol_valid (o_symbol_valid),
        .o_distance     (o_distance),
        .o_locked       (o_locked)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference chip table, built from the textual sequence.
    bit ref_tab [16][32];

    task automatic build_table();
        string s;
        bit    base [32];
        s = "11011001110000110101001000101110";
        for (int i = 0; i < 32; i++) base[i] = (s[i] == 8'h31);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 32; i++) begin
                ref_tab[k][i]     = base[(i - 4 * k + 32) % 32];
                ref_tab[k + 8][i] = ref_tab[k][i] ^ (i % 2 == 1);
            end
        end
    endtask

    // Behavioural model: last 32 valid chips in a queue, lock bookkeeping by
    // counting chips since alignment.
    bit m_hist[$];
    int m_fill, m_pos, m_miss, m_last_sym, m_last_dist;
    bit m_locked, m_exp_v;

    function automatic int m_dist(int k);
        int d;
        d = 0;
        for (int i = 0; i < 32; i++) d += (m_hist[i] != ref_tab[k][i]) ? 1 : 0;
        return d;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_fill = 0; m_pos = 0; m_miss = 0;
        m_locked = 0; m_exp_v = 0;
        m_last_sym = 0; m_last_dist = 0;
    endtask

    task automatic model_step(input bit b);
        int best, best_k, d;
        m_hist.push_back(b);
        if (m_hist.size() > 32) m_hist.delete(0);
        m_exp_v = 0;
        if (!m_locked) begin
            if (m_fill < 32) m_fill++;
            if (m_fill == 32 && m_dist(0) <= MAXE) begin
                m_locked = 1; m_pos = 0; m_miss = 0;
                m_exp_v = 1; m_last_sym = 0; m_last_dist = m_dist(0);
            end
        end else begin
            m_pos++;
            if (m_pos == 32) begin
                m_pos = 0;
                best = 99; best_k = 0;
                for (int k = 0; k < 16; k++) begin
                    d = m_dist(k);
                    if (d < best) begin best = d; best_k = k; end
                end
                if (best <= MAXE) begin
                    m_exp_v = 1; m_last_sym = best_k; m_last_dist = best; m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss == LOSS) begin m_locked = 0; m_fill = 0; m_miss = 0; end
                end
            end
        end
    endtask

    int g_n, lock_at, unlock_at, strobes;
    bit prev_locked = 0;

    task automatic observe();
        check("valid", 32'(o_symbol_valid), 32'(m_exp_v));
        check("symbol", 32'(o_symbol), 32'(m_last_sym));
        check("distance", 32'(o_distance), 32'(m_last_dist));
        check("locked", 32'(o_locked), 32'(m_locked));
        if (o_symbol_valid) strobes++;
        if (o_locked && !prev_locked && lock_at < 0) lock_at = g_n;
        if (!o_locked && prev_locked && unlock_at < 0) unlock_at = g_n;
        prev_locked = o_locked;
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_chip_valid = 1'b0;
        i_chip = 1'($urandom);
        m_exp_v = 0;
        @(posedge i_clk);
        #1;
        observe();
    endtask

    task automatic step(input bit b, input bit gaps);
        int n;
        @(negedge i_clk);
        i_chip = b;
        i_chip_valid = 1'b1;
        g_n++;
        model_step(b);
        @(posedge i_clk);
        #1;
        observe();
        i_chip_valid = 1'b0;
        if (gaps) begin
            n = 0;
            while ($urandom_range(0, 1) == 1 && n < 6) begin
                idle();
                n++;
            end
        end
    endtask

    task automatic send_sym(input int k, input int nflip, input bit gaps);
        bit flip [32];
        int cnt, p;
        for (int i = 0; i < 32; i++) flip[i] = 0;
        cnt = 0;
        while (cnt < nflip) begin
            p = $urandom_range(0, 31);
            if (!flip[p]) begin flip[p] = 1; cnt++; end
        end
        for (int i = 0; i < 32; i++) step(ref_tab[k][i] ^ flip[i], gaps);
    endtask

    // Asserts reset immediately (callers stay away from clock edges) and
    // checks that outputs clear without waiting for a clock.
    task automatic reset_now();
        i_rst_n = 1'b0;
        #1;
        check("rst_symbol", 32'(o_symbol), 32'd0);
        check("rst_valid", 32'(o_symbol_valid), 32'd0);
        check("rst_distance", 32'(o_distance), 32'd0);
        check("rst_locked", 32'(o_locked), 32'd0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        prev_locked = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        build_table();
        model_reset();
        #2;
        reset_now();

        // Clean contiguous stream: 0, 0, 7, 0xA.
        g_n = 0; lock_at = -1; strobes = 0;
        send_sym(0, 0, 0);
        send_sym(0, 0, 0);
        send_sym(7, 0, 0);
        send_sym(10, 0, 0);
        check("clean_lock_at", 32'(lock_at), 32'd32);
        check("clean_strobes", 32'(strobes), 32'd4);
        check("clean_last_symbol", 32'(o_symbol), 32'd10);

        // Reset while the last strobe is still high.
        #2;
        reset_now();

        // Chip errors.
        g_n = 0; lock_at = -1;
        send_sym(0, 0, 0);
        strobes = 0;
        send_sym(5, 3, 0);
        check("err3_strobes", 32'(strobes), 32'd1);
        check("err3_symbol", 32'(o_symbol), 32'd5);
        check("err3_distance", 32'(o_distance), 32'd3);
        send_sym(5, 7, 0);
        check("err7_strobes", 32'(strobes), 32'd1);
        check("err7_still_locked", 32'(o_locked), 32'd1);
        send_sym(2, 0, 0);
        check("err_recover_symbol", 32'(o_symbol), 32'd2);

        // Partial window discarded by reset.
        for (int i = 0; i < 20; i++) step(ref_tab[0][i], 0);
        #2;
        reset_now();
        g_n = 0; lock_at = -1;
        send_sym(0, 0, 0);
        check("post_rst_lock_at", 32'(lock_at), 32'd32);

        // Misalignment: 13 random chips before the preamble.
        #2;
        reset_now();
        g_n = 0; lock_at = -1;
        for (int i = 0; i < 13; i++) step(1'($urandom), 0);
        send_sym(0, 0, 0);
        for (int s = 0; s < 4; s++) send_sym($urandom_range(0, 15), 0, 0);
        check("misalign_lock_at", 32'(lock_at), 32'd45);

        // Loss of lock on 64 all-ones chips.
        g_n = 0; unlock_at = -1; strobes = 0;
        for (int i = 0; i < 64; i++) step(1'b1, 0);
        check("loss_unlock_at", 32'(unlock_at), 32'd64);
        check("loss_strobes", 32'(strobes), 32'd0);

        // Random gaps in the valid stream.
        #2;
        reset_now();
        g_n = 0; lock_at = -1; strobes = 0;
        send_sym(0, 0, 1);
        for (int s = 0; s < 7; s++) send_sym($urandom_range(0, 15), 0, 1);
        check("gap_lock_at", 32'(lock_at), 32'd32);
        check("gap_strobes", 32'(strobes), 32'd8);

        // Random symbols with random chip errors, gaps on.
        for (int s = 0; s < 8; s++) send_sym($urandom_range(0, 15), $urandom_range(0, 8), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chip_to_symbol_despreader.md
CHIP_TO_SYMBOL_DESPREADER -- requirements
Module: chip_to_symbol_despreader

Interface
REQ-001 SHALL have parameter CHIP_WIDTH, default 32, meaning chips per symbol.
REQ-002 SHALL have parameter SYMBOL_WIDTH, default 4, meaning data bits per symbol.
REQ-003 SHALL have parameter NUM_OF_CHIPS, default 16, meaning number of candidate chip sequences.
REQ-004 SHALL have parameter MAX_ERR, default 6, meaning the largest Hamming distance accepted as a match.
REQ-005 SHALL have parameter LOSS_COUNT, default 2, meaning the number of consecutive missed windows that drops lock.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port i_chip, input, 1 bit: hard-decision chip.
REQ-009 SHALL have port i_chip_valid, input, 1 bit: i_chip is sampled only on edges where this is high.
REQ-010 SHALL have port o_symbol, output, SYMBOL_WIDTH bits: decoded symbol.
REQ-011 SHALL have port o_symbol_valid, output, 1 bit: one-cycle strobe qualifying o_symbol.
REQ-012 SHALL have port o_distance, output, 6 bits: Hamming distance of the emitted symbol.
REQ-013 SHALL have port o_locked, output, 1 bit: high while in state LOCKED.

Function
REQ-014 Chip table SHALL be fixed. Symbol 0 is c0..c31 = 11011001110000110101001000101110, with c0 first on air.
REQ-015 Symbol k (1..7) SHALL be symbol 0 rotated right by 4k chips: c_i(k) = c_((i-4k) mod 32)(0).
REQ-016 Symbol k (8..15) SHALL be symbol k-8 with odd-indexed chips inverted.
REQ-017 A 32-bit window register SHALL shift on each valid chip, so that w[31] is the newest chip and w[0] is the oldest; distance(k) = popcount(w[i] XOR c_i(k)) over i = 0..31.
REQ-018 When i_chip_valid is low, window, counters and state SHALL hold, so gaps may occur anywhere, including mid-symbol.
REQ-019 States SHALL be SEARCH and LOCKED; reset enters SEARCH.
REQ-020 In SEARCH, a fill counter SHALL count valid chips, saturating at 32; it is cleared on entry to SEARCH.
REQ-021 In SEARCH, on each valid-chip edge where the fill count, including this chip, is at least 32, the block SHALL evaluate distance(0) on the updated window.
REQ-022 In SEARCH, if distance(0) <= MAX_ERR on that edge, the next edge SHALL do all of the following: enter LOCKED, clear the chip counter and miss counter, and drive o_symbol=0, o_distance=distance(0), o_symbol_valid=1.
REQ-023 In LOCKED, a 5-bit chip counter SHALL count valid chips 0..31 and wrap; the window completes on the chip that makes the count 31.
REQ-024 At window completion, the block SHALL select the minimum distance over all 16 candidates; ties resolve to the lowest index.
REQ-025 If the minimum <= MAX_ERR, o_symbol, o_distance and o_symbol_valid=1 SHALL update at the edge after the completing chip, and the miss counter clears.
REQ-026 If the minimum > MAX_ERR, o_symbol_valid SHALL stay 0 and the miss counter SHALL increment.
REQ-027 When the miss counter reaches LOSS_COUNT, the block SHALL enter SEARCH on that same update edge, with o_locked=0 and the fill counter cleared.
REQ-028 o_symbol_valid SHALL be high for exactly one cycle per accepted window, never in consecutive cycles from the same window.
REQ-029 o_symbol and o_distance SHALL hold their last value when o_symbol_valid is low.
REQ-030 Distance arithmetic SHALL be unsigned, 6 bits, range 0..32, and SHALL not overflow.

Reset
REQ-031 When i_rst_n is low, the block SHALL immediately clear o_symbol=0, o_symbol_valid=0, o_distance=0 and o_locked=0, along with the window, all counters and the state (SEARCH), regardless of clock.
REQ-032 Reset asserted mid-window SHALL discard all partially received chips; after release, 32 new valid chips are required before any compare.

Verification
REQ-033 Reset check: assert i_rst_n=0 mid-operation -> all outputs 0 within the same cycle, o_locked=0.
REQ-034 Clean stream: symbol 0 twice, then symbol 7, then symbol 0xA, all contiguous -> lock after chip 32, emitting o_symbol=0; then 0, 7 and 0xA strobes one edge after chips 64, 96 and 128; o_distance=0 throughout.
REQ-035 Errors: lock, then send symbol 5 with 3 flipped chips -> o_symbol=5, o_distance=3; with 7 flipped chips -> no strobe and miss count 1.
REQ-036 Misalignment: 13 random chips, then symbol-0 preamble -> lock exactly after valid chip 45; subsequent symbols decode correctly.
REQ-037 Loss of lock: after lock, send 64 all-ones chips (distance 16 to every sequence) -> no strobes; o_locked falls at the edge after chip 64 of that run.
REQ-038 Gaps: clean symbols with i_chip_valid randomly deasserted 50% of cycles -> same symbols and distances as the contiguous case; only timing differs.
